ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends command bytes to the keyboard or mouse, such as reset (0xFF), set LEDs (0xED) or enable reporting (0xF4). It is the transmit side of the PS/2 slave peripheral, alongside the existing receive core. The Avalon register layer feeds it one byte per valid/ready handshake, and the block drives the open-drain PS/2 clock and data lines through active-high output-enable (pull-low) signals.

---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Byte handshake and status bundle between the register layer and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_ack_err, tx_timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_ack_err, tx_timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10 bits on device clock falls,
// ACK sampling and return to idle bus, with a single transfer watchdog.
//
// state     | meaning
// IDLE      | lines released, ready for a byte
// INHIBIT   | hold ps2 clock low for INHIBIT_CYCLES
// REQ       | one cycle with clock and data low (start bit)
// SHIFT     | clock released; data, parity, stop presented on falls
// ACK       | wait for 11th fall, sample device ACK
// WAIT_IDLE | wait for clock and data both high, then report
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic          clk,
  input  logic          reset,
  ps2_host_tx_if.slave  tx,
  input  logic          ps2_clk_i,
  input  logic          ps2_data_i,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
  } state_t;

  state_t           state, state_nx;
  logic [1:0]       clk_sync_r, data_sync_r;
  logic             clk_sync, data_sync, clk_prev, fall;
  logic [9:0]       shreg;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             data_bit_oe;
  logic             ack_ok, ack_bad;
  logic             accept, to_active, to_hit, idle_seen;
  logic             done_p, err_p, to_p;

  // Idle bus is high, so synchronizers come out of reset at 1 to avoid a false fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
      clk_prev    <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk_i};
      data_sync_r <= {data_sync_r[0], ps2_data_i};
      clk_prev    <= clk_sync_r[1];
    end
  end

  assign clk_sync  = clk_sync_r[1];
  assign data_sync = data_sync_r[1];
  assign fall      = clk_prev & ~clk_sync;
  assign idle_seen = clk_sync & data_sync;
  assign accept    = tx.tx_valid && (state == IDLE);
  assign to_active = (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  assign to_hit    = to_active && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done_p      = 1'b0;
    err_p       = 1'b0;
    to_p        = 1'b0;
    case (state)
      IDLE:      if (accept) state_nx = INHIBIT;
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) state_nx = REQ;
      end
      REQ: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        state_nx    = SHIFT;
      end
      SHIFT: begin
        ps2_data_oe = data_bit_oe;
        if (fall && bit_cnt == 4'd9) state_nx = ACK;
      end
      ACK:       if (fall) state_nx = WAIT_IDLE;
      WAIT_IDLE: if (idle_seen) begin
        state_nx = IDLE;
        done_p   = ack_ok;
        err_p    = ack_bad;
      end
      default:   state_nx = IDLE;
    endcase
    // Watchdog wins over any fall or idle detection in the same cycle.
    if (to_hit) begin
      state_nx    = IDLE;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      done_p      = 1'b0;
      err_p       = 1'b0;
      to_p        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      inh_cnt     <= '0;
      to_cnt      <= '0;
      data_bit_oe <= 1'b0;
      ack_ok      <= 1'b0;
      ack_bad     <= 1'b0;
    end else begin
      to_cnt <= to_active ? to_cnt + TO_W'(1) : '0;
      case (state)
        IDLE: if (accept) begin
          shreg   <= {1'b1, ~^tx.tx_data, tx.tx_data};
          bit_cnt <= '0;
          inh_cnt <= '0;
          ack_ok  <= 1'b0;
          ack_bad <= 1'b0;
        end
        INHIBIT: inh_cnt <= inh_cnt + INH_W'(1);
        REQ:     data_bit_oe <= 1'b1;
        SHIFT: if (fall) begin
          data_bit_oe <= ~shreg[0];
          shreg       <= {1'b0, shreg[9:1]};
          if (bit_cnt != 4'd10) bit_cnt <= bit_cnt + 4'd1;
        end
        ACK: if (fall) begin
          ack_ok  <= ~data_sync;
          ack_bad <= data_sync;
        end
        default: ;
      endcase
    end
  end

  assign tx.tx_ready   = (state == IDLE);
  assign tx.busy       = (state != IDLE);
  assign tx.tx_done    = done_p;
  assign tx.tx_ack_err = err_p;
  assign tx.tx_timeout = to_p;

endmodule
